game_round_ctrl: RTL and testbench
==================================

GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 SHALL have parameter MAX_TRIES, default 17, giving the guesses allowed per round (1..31).
REQ-002 SHALL have parameter DIGITS, default 4, giving the number of 4-bit digits per code (fixed at 4 this revision).
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 secret_load  in  1  capture secret_in (SET state only).
REQ-006 secret_in  in  16  secret code, digit 3 = [15:12] … digit 0 = [3:0].
REQ-007 start  in  1  single-cycle pulse: begin round (SET) / return to SET (DONE).
REQ-008 guess_valid  in  1  guess offered.
REQ-009 guess  in  16  guess code, same digit layout as secret_in.
REQ-010 guess_ready  out  1  high only in PLAY.
REQ-011 score_valid  out  1  one-cycle pulse when a_cnt/b_cnt are updated.
REQ-012 a_cnt  out  3  exact-position matches of the last scored guess (0..4).
REQ-013 b_cnt  out  3  wrong-position matches of the last scored guess (0..4).
REQ-014 attempts  out  5  guesses scored this round.
REQ-015 state  out  2  SET=0, PLAY=1, SCORE=2, DONE=3.
REQ-016 win / lose  out  1 each  round result, held in DONE.

Function
REQ-017 SET: secret_load=1 registers secret_in and sets the internal secret_ok flag; start with secret_ok=1 enters PLAY, clears attempts, a_cnt and b_cnt.
REQ-018 SET: start with secret_ok=0 is ignored; when secret_load and start coincide, the load takes effect and start is ignored.
REQ-019 PLAY: guess_valid&&guess_ready registers guess, clears the score accumulators, sets digit index to 3 and enters SCORE.
REQ-020 SCORE: exactly 4 cycles, one digit per cycle (index 3,2,1,0); guess_ready=0, so guess_valid is ignored.
REQ-021 Per digit i: if guess[i]==secret[i], the A accumulator increments; else, if guess[i] equals any secret[j] with j≠i, the B accumulator increments; each guess digit adds at most 1 in total.
REQ-022 Secret and guess digits are not validated; duplicate digits and values 10..15 are scored per REQ-021 without error.
REQ-023 Latency: guess accepted at edge N; a_cnt, b_cnt and attempts (+1) update and score_valid=1 at edge N+4.
REQ-024 After the 4th digit: if A==4, go to DONE with win=1; else if the new attempts==MAX_TRIES, go to DONE with lose=1; else return to PLAY.
REQ-025 When A==4 on the MAX_TRIES-th guess, the result is win, not lose.
REQ-026 attempts saturates at MAX_TRIES and never wraps.
REQ-027 DONE: a_cnt, b_cnt, attempts, win and lose are held; start enters SET and clears win, lose, a_cnt, b_cnt, attempts and secret_ok.
REQ-028 start is ignored in PLAY and SCORE; secret_load is ignored outside SET.
REQ-029 win and lose are never both 1.

Reset
REQ-030 rst=1 asynchronously forces state=SET and clears secret_ok, the secret, the guess registers, the accumulators, a_cnt, b_cnt, attempts, win, lose, score_valid and guess_ready.
REQ-031 rst asserted mid-SCORE aborts scoring with no score_valid pulse; after release the block waits in SET for a new secret.

Structure
REQ-032 Shared package game_pkg SHALL hold the state encoding (SET/PLAY/SCORE/DONE), the digit width 4, DIGITS and the default MAX_TRIES.
REQ-033 One combinational sub-module digit_match SHALL take (guess digit, index, secret) and return {exact, misplaced}, instantiated once and time-shared across the 4 SCORE cycles.

Verification
REQ-034 secret 0x1234 loaded, start, guess 0x1234 at edge N → score_valid at N+4 with A=4, B=0, attempts=1, state=DONE, win=1.
REQ-035 secret 0x1234, guess 0x4321 → A=0, B=4; guess 0x1243 → A=2, B=2; guess 0x1111 → A=1, B=3; state returns to PLAY each time.
REQ-036 secret 0x1234, 17 consecutive guesses of 0x5678 → each gives A=0, B=0; after the 17th, attempts=17, lose=1, win=0, DONE.
REQ-037 guess_valid held high during SCORE with a different guess value → only the first guess is scored, guess_ready=0 for 4 cycles.
REQ-038 rst pulsed during the 2nd SCORE cycle → no score_valid, state=SET, all outputs 0; start without secret_load stays in SET.
REQ-039 secret_load and start in the same cycle → stays in SET; start on the next cycle → PLAY using the new secret.

Source files
------------

// File: rtl/game_round_ctrl_pkg.sv
// Shared definitions for the guess-and-score round controller: state encoding,
// code geometry and the default number of guesses per round.
package game_pkg;

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_PLAY  = 2'd1,
    ST_SCORE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned DIGIT_W       = 4;
  localparam int unsigned DIGITS        = 4;
  localparam int unsigned CODE_W        = DIGITS * DIGIT_W;
  localparam int unsigned MAX_TRIES_DEF = 17;

endpackage

// File: rtl/game_round_ctrl_digit_match.sv
// Scores one guess digit against the whole secret: exact hit at the same
// position, otherwise a hit at any other position counts as misplaced.
module digit_match
  import game_pkg::*;
(
  input  logic [DIGIT_W-1:0] guess_digit_i,
  input  logic [1:0]         idx_i,
  input  logic [CODE_W-1:0]  secret_i,
  output logic               exact_o,
  output logic               misplaced_o
);

  logic any_other;

  always_comb begin
    any_other = 1'b0;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      if ((j != 32'(idx_i)) && (secret_i[j*DIGIT_W +: DIGIT_W] == guess_digit_i)) begin
        any_other = 1'b1;
      end
    end
  end

  assign exact_o     = (secret_i[{idx_i, 2'b00} +: DIGIT_W] == guess_digit_i);
  // Exact wins so a digit never contributes to both counters.
  assign misplaced_o = any_other && !exact_o;

endmodule

// File: rtl/game_round_ctrl.sv
// Round controller: holds a secret code, scores guesses one digit per cycle
// through a shared matcher, and tracks attempts up to a win or loss.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned MAX_TRIES = MAX_TRIES_DEF,
  parameter int unsigned DIGITS    = game_pkg::DIGITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      secret_load,
  input  logic [DIGITS*DIGIT_W-1:0] secret_in,
  input  logic                      start,
  input  logic                      guess_valid,
  input  logic [DIGITS*DIGIT_W-1:0] guess,
  output logic                      guess_ready,
  output logic                      score_valid,
  output logic [2:0]                a_cnt,
  output logic [2:0]                b_cnt,
  output logic [4:0]                attempts,
  output logic [1:0]                state,
  output logic                      win,
  output logic                      lose
);

  localparam logic [4:0] MAX_A = 5'(MAX_TRIES);

  state_e                    state_q, state_d;
  logic [DIGITS*DIGIT_W-1:0] secret_q, guess_q;
  logic                      secret_ok_q;
  logic [1:0]                idx_q;
  logic [2:0]                acc_a_q, acc_b_q, a_cnt_q, b_cnt_q;
  logic [4:0]                att_q;
  logic                      win_q, lose_q, sv_q;

  logic                      exact, misplaced, last_digit;
  logic [2:0]                a_fin, b_fin;
  logic [4:0]                att_inc;

  digit_match u_match (
    .guess_digit_i (guess_q[{idx_q, 2'b00} +: DIGIT_W]),
    .idx_i         (idx_q),
    .secret_i      (secret_q),
    .exact_o       (exact),
    .misplaced_o   (misplaced)
  );

  assign a_fin      = acc_a_q + 3'(exact);
  assign b_fin      = acc_b_q + 3'(misplaced);
  assign att_inc    = (att_q == MAX_A) ? att_q : att_q + 5'd1;
  assign last_digit = (state_q == ST_SCORE) && (idx_q == 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_SET;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SET:   if (!secret_load && start && secret_ok_q) state_d = ST_PLAY;
      ST_PLAY:  if (guess_valid) state_d = ST_SCORE;
      ST_SCORE: begin
        if (last_digit) begin
          if (a_fin == 3'd4 || att_inc == MAX_A) state_d = ST_DONE;
          else                                   state_d = ST_PLAY;
        end
      end
      ST_DONE:  if (start) state_d = ST_SET;
      default:  state_d = ST_SET;
    endcase
  end

  always_comb begin
    guess_ready = (state_q == ST_PLAY);
    state       = state_q;
    score_valid = sv_q;
    a_cnt       = a_cnt_q;
    b_cnt       = b_cnt_q;
    attempts    = att_q;
    win         = win_q;
    lose        = lose_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      secret_q    <= '0;
      secret_ok_q <= 1'b0;
      guess_q     <= '0;
      idx_q       <= '0;
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      a_cnt_q     <= '0;
      b_cnt_q     <= '0;
      att_q       <= '0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
      sv_q        <= 1'b0;
    end else begin
      sv_q <= 1'b0;
      case (state_q)
        ST_SET: begin
          if (secret_load) begin
            secret_q    <= secret_in;
            secret_ok_q <= 1'b1;
          end else if (start && secret_ok_q) begin
            att_q   <= '0;
            a_cnt_q <= '0;
            b_cnt_q <= '0;
          end
        end
        ST_PLAY: begin
          if (guess_valid) begin
            guess_q <= guess;
            acc_a_q <= '0;
            acc_b_q <= '0;
            idx_q   <= 2'd3;
          end
        end
        ST_SCORE: begin
          // The final digit's contribution goes straight to the outputs.
          if (last_digit) begin
            a_cnt_q <= a_fin;
            b_cnt_q <= b_fin;
            att_q   <= att_inc;
            sv_q    <= 1'b1;
            win_q   <= (a_fin == 3'd4);
            lose_q  <= (a_fin != 3'd4) && (att_inc == MAX_A);
          end else begin
            acc_a_q <= a_fin;
            acc_b_q <= b_fin;
            idx_q   <= idx_q - 2'd1;
          end
        end
        ST_DONE: begin
          if (start) begin
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
            a_cnt_q     <= '0;
            b_cnt_q     <= '0;
            att_q       <= '0;
            secret_ok_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl: stimulus pushes expected scores into a
// queue, a negedge monitor pops and compares on each score_valid pulse.
module tb_game_round_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        secret_load = 1'b0;
  logic [15:0] secret_in = '0;
  logic        start = 1'b0;
  logic        guess_valid = 1'b0;
  logic [15:0] guess = '0;
  logic        guess_ready, score_valid, win, lose;
  logic [2:0]  a_cnt, b_cnt;
  logic [4:0]  attempts;
  logic [1:0]  state;

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [4:0] att;
    logic [1:0] st;
    logic       w;
    logic       l;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  game_round_ctrl #(.MAX_TRIES(17), .DIGITS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .secret_load (secret_load),
    .secret_in   (secret_in),
    .start       (start),
    .guess_valid (guess_valid),
    .guess       (guess),
    .guess_ready (guess_ready),
    .score_valid (score_valid),
    .a_cnt       (a_cnt),
    .b_cnt       (b_cnt),
    .attempts    (attempts),
    .state       (state),
    .win         (win),
    .lose        (lose)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // {state, guess_ready, score_valid, a, b, attempts, win, lose}
  function automatic logic [16:0] outv();
    return {state, guess_ready, score_valid, a_cnt, b_cnt, attempts, win, lose};
  endfunction

  always @(negedge clk) begin
    if (rst !== 1'b1 && score_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_score_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("score_a",       32'(a_cnt),    32'(e.a));
        chk("score_b",       32'(b_cnt),    32'(e.b));
        chk("score_att",     32'(attempts), 32'(e.att));
        chk("score_state",   32'(state),    32'(e.st));
        chk("score_win",     32'(win),      32'(e.w));
        chk("score_lose",    32'(lose),     32'(e.l));
        chk("score_latency", 32'(cyc),      32'(e.cyc));
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
  endtask

  task automatic load_secret(input logic [15:0] s, input logic with_start);
    @(negedge clk);
    secret_load = 1'b1;
    secret_in   = s;
    start       = with_start;
    @(posedge clk) #1;
    secret_load = 1'b0;
    start       = 1'b0;
  endtask

  task automatic send_guess(input logic [15:0] g, input logic [2:0] a, input logic [2:0] b,
                            input logic [4:0] att, input logic [1:0] st,
                            input logic w, input logic l, input logic push);
    exp_t e;
    @(negedge clk);
    guess_valid = 1'b1;
    guess       = g;
    @(posedge clk) #1;
    guess_valid = 1'b0;
    chk("accept_to_score", 32'(state), 32'd2);
    if (push) begin
      e = '{a: a, b: b, att: att, st: st, w: w, l: l, cyc: cyc + 4};
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    #1 chk("scoreboard_drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    #12;
    chk("reset_outputs", 32'(outv()), 32'd0);
    @(negedge clk) rst = 1'b0;

    pulse_start();
    #1 chk("start_without_secret", 32'(state), 32'd0);

    load_secret(16'h1234, 1'b1);
    #1 chk("load_with_start_stays_set", 32'(state), 32'd0);
    pulse_start();
    #1 chk("start_enters_play", 32'(outv()), {2'd1, 1'b1, 14'd0});

    send_guess(16'h4321, 3'd0, 3'd4, 5'd1, 2'd1, 1'b0, 1'b0, 1'b1); drain();
    send_guess(16'h1243, 3'd2, 3'd2, 5'd2, 2'd1, 1'b0, 1'b0, 1'b1); drain();
    send_guess(16'h1111, 3'd1, 3'd3, 5'd3, 2'd1, 1'b0, 1'b0, 1'b1); drain();

    // Keep guess_valid high with a winning code while the first guess scores.
    send_guess(16'h5678, 3'd0, 3'd0, 5'd4, 2'd1, 1'b0, 1'b0, 1'b1);
    guess_valid = 1'b1;
    guess       = 16'h1234;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("ready_low_in_score", 32'(guess_ready), 32'd0);
    end
    guess_valid = 1'b0;
    drain();

    send_guess(16'h1234, 3'd4, 3'd0, 5'd5, 2'd3, 1'b1, 1'b0, 1'b1); drain();
    load_secret(16'h9999, 1'b0);
    repeat (3) @(negedge clk);
    chk("done_hold", 32'(outv()), {2'd3, 1'b0, 1'b0, 3'd4, 3'd0, 5'd5, 1'b1, 1'b0});
    pulse_start();
    #1 chk("done_to_set_clear", 32'(outv()), 32'd0);
    pulse_start();
    #1 chk("secret_ok_cleared", 32'(state), 32'd0);

    load_secret(16'h1234, 1'b0);
    pulse_start();
    for (int i = 1; i <= 17; i++) begin
      send_guess(16'h5678, 3'd0, 3'd0, 5'(i), (i == 17) ? 2'd3 : 2'd1, 1'b0, (i == 17), 1'b1);
      drain();
    end
    #1 chk("lose_final", 32'(outv()), {2'd3, 1'b0, 1'b0, 3'd0, 3'd0, 5'd17, 1'b0, 1'b1});

    pulse_start();
    load_secret(16'h1234, 1'b0);
    pulse_start();
    for (int i = 1; i <= 16; i++) begin
      send_guess(16'h5678, 3'd0, 3'd0, 5'(i), 2'd1, 1'b0, 1'b0, 1'b1);
      drain();
    end
    send_guess(16'h1234, 3'd4, 3'd0, 5'd17, 2'd3, 1'b1, 1'b0, 1'b1); drain();

    pulse_start();
    load_secret(16'hABCD, 1'b0);
    pulse_start();
    send_guess(16'hDCBA, 3'd0, 3'd4, 5'd1, 2'd1, 1'b0, 1'b0, 1'b1); drain();
    send_guess(16'hAAAA, 3'd1, 3'd3, 5'd2, 2'd1, 1'b0, 1'b0, 1'b1); drain();
    send_guess(16'hA0CF, 3'd2, 3'd0, 5'd3, 2'd1, 1'b0, 1'b0, 1'b1); drain();

    // Abort a scoring pass with reset during its second digit cycle.
    send_guess(16'hABCD, 3'd0, 3'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk) #1 rst = 1'b1;
    #1 chk("async_reset_clear", 32'(outv()), 32'd0);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (score_valid === 1'b1) seen++;
    end
    chk("no_score_after_abort", 32'(seen), 32'd0);
    chk("idle_after_abort", 32'(outv()), 32'd0);
    pulse_start();
    #1 chk("abort_needs_new_secret", 32'(state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
